// File: rtl/mips_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mips_pipe_pkg
//  Purpose  : Shared definitions for the pipelined MIPS core stage registers.
//             Control-bundle layout, the hard-wired zero register index and
//             the stage-register update-action encoding.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package mips_pipe_pkg;

   // Opaque control bundle carried from decode to execute.
   localparam int CTRL_W         = 8;
   localparam int CTRL_ALUOP_LSB = 0;   // 1-bit ALU operation class
   localparam int CTRL_ALUSRC    = 1;
   localparam int CTRL_REGDST    = 2;
   localparam int CTRL_MEMREAD   = 3;
   localparam int CTRL_MEMWRITE  = 4;
   localparam int CTRL_REGWRITE  = 5;
   localparam int CTRL_MEMTOREG  = 6;
   localparam int CTRL_BRANCH    = 7;

   // $0 is hard-wired to zero: never a real dependency.
   localparam int REG_ZERO = 0;

   // Per-edge action of a stage register, in priority order.
   typedef enum logic [1:0] {
      UPD_FLUSH  = 2'd0,
      UPD_HOLD   = 2'd1,
      UPD_BUBBLE = 2'd2,
      UPD_LOAD   = 2'd3
   } upd_e;

endpackage
`default_nettype wire

// File: rtl/load_use_detect.sv
`default_nettype none
// ============================================================================
//  Module   : load_use_detect
//  Purpose  : Combinational load-use hazard compare between the instruction
//             in EX (a load) and the instruction in decode.
//  Ports    : ex_valid_i, ex_mem_read_i, ex_rt_i  - state of the EX stage
//             id_valid_i, id_rs_i, id_rt_i,
//             id_uses_rt_i                         - decode sources
//             hazard_o                             - bubble required
//  Revision : 1.0 - initial release
// ============================================================================
module load_use_detect #(
   parameter int REG_AW = 5
) (
   input  logic              ex_valid_i,
   input  logic              ex_mem_read_i,
   input  logic [REG_AW-1:0] ex_rt_i,
   input  logic              id_valid_i,
   input  logic [REG_AW-1:0] id_rs_i,
   input  logic [REG_AW-1:0] id_rt_i,
   input  logic              id_uses_rt_i,
   output logic              hazard_o
);
   import mips_pipe_pkg::*;

   logic ex_rt_nonzero;
   logic rs_match;
   logic rt_match;

   assign ex_rt_nonzero = (ex_rt_i != REG_AW'(REG_ZERO));
   assign rs_match      = (ex_rt_i == id_rs_i);
   assign rt_match      = id_uses_rt_i && (ex_rt_i == id_rt_i);

   assign hazard_o = ex_valid_i && ex_mem_read_i && id_valid_i &&
                     ex_rt_nonzero && (rs_match || rt_match);

endmodule
`default_nettype wire

// File: rtl/id_ex_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module   : id_ex_stage_reg
//  Purpose  : ID/EX pipeline register with valid bit, stall hold, flush,
//             load-use bubble insertion, optional WB->decode operand bypass
//             and a saturating bubble counter.
//  Ports    : clk, rst                  - clock, async active-high reset
//             id_*_i                    - decode-stage instruction fields
//             wb_we_i, wb_rd_i, wb_data_i - write-back port (bypass source)
//             stall_in_i, flush_i       - downstream hold / kill
//             ex_*_o                    - registered execute-stage fields
//             id_stall_o                - freeze PC and IF/ID
//             bubble_cnt_o              - load-use bubbles inserted
//  Revision : 1.0 - initial release
// ============================================================================
module id_ex_stage_reg #(
   parameter int DATA_W    = 32,
   parameter int REG_AW    = 5,
   parameter int CTRL_W    = mips_pipe_pkg::CTRL_W,
   parameter int WB_BYPASS = 1,
   parameter int BCNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid_i,
   input  logic [DATA_W-1:0] id_pc_i,
   input  logic [DATA_W-1:0] id_rd1_i,
   input  logic [DATA_W-1:0] id_rd2_i,
   input  logic [DATA_W-1:0] id_imm_i,
   input  logic [REG_AW-1:0] id_rs_i,
   input  logic [REG_AW-1:0] id_rt_i,
   input  logic [REG_AW-1:0] id_rd_i,
   input  logic              id_uses_rt_i,
   input  logic [CTRL_W-1:0] id_ctrl_i,
   input  logic              id_mem_read_i,
   input  logic              wb_we_i,
   input  logic [REG_AW-1:0] wb_rd_i,
   input  logic [DATA_W-1:0] wb_data_i,
   input  logic              stall_in_i,
   input  logic              flush_i,
   output logic              ex_valid_o,
   output logic [DATA_W-1:0] ex_pc_o,
   output logic [DATA_W-1:0] ex_rd1_o,
   output logic [DATA_W-1:0] ex_rd2_o,
   output logic [DATA_W-1:0] ex_imm_o,
   output logic [REG_AW-1:0] ex_rs_o,
   output logic [REG_AW-1:0] ex_rt_o,
   output logic [REG_AW-1:0] ex_rd_o,
   output logic [CTRL_W-1:0] ex_ctrl_o,
   output logic              ex_mem_read_o,
   output logic              id_stall_o,
   output logic [BCNT_W-1:0] bubble_cnt_o
);
   import mips_pipe_pkg::*;

   logic              ex_valid_q,    ex_valid_d;
   logic [DATA_W-1:0] ex_pc_q,       ex_pc_d;
   logic [DATA_W-1:0] ex_rd1_q,      ex_rd1_d;
   logic [DATA_W-1:0] ex_rd2_q,      ex_rd2_d;
   logic [DATA_W-1:0] ex_imm_q,      ex_imm_d;
   logic [REG_AW-1:0] ex_rs_q,       ex_rs_d;
   logic [REG_AW-1:0] ex_rt_q,       ex_rt_d;
   logic [REG_AW-1:0] ex_rd_q,       ex_rd_d;
   logic [CTRL_W-1:0] ex_ctrl_q,     ex_ctrl_d;
   logic              ex_mem_read_q, ex_mem_read_d;
   logic [BCNT_W-1:0] bubble_cnt_q,  bubble_cnt_d;

   logic              hazard;
   logic [DATA_W-1:0] op1;
   logic [DATA_W-1:0] op2;
   upd_e              upd_sel;

   // Hazard is judged on the pre-edge EX contents; a bubble clears
   // ex_mem_read so each load-use pair costs exactly one cycle.
   load_use_detect #(
      .REG_AW (REG_AW)
   ) u_load_use_detect (
      .ex_valid_i    (ex_valid_q),
      .ex_mem_read_i (ex_mem_read_q),
      .ex_rt_i       (ex_rt_q),
      .id_valid_i    (id_valid_i),
      .id_rs_i       (id_rs_i),
      .id_rt_i       (id_rt_i),
      .id_uses_rt_i  (id_uses_rt_i),
      .hazard_o      (hazard)
   );

   // Register file is write-first from the pipeline's point of view: a
   // same-cycle WB write to a source register is forwarded into decode.
   generate
      if (WB_BYPASS != 0) begin : g_wb_bypass
         logic wb_hit_rs;
         logic wb_hit_rt;
         assign wb_hit_rs = wb_we_i && (wb_rd_i != REG_AW'(REG_ZERO)) && (wb_rd_i == id_rs_i);
         assign wb_hit_rt = wb_we_i && (wb_rd_i != REG_AW'(REG_ZERO)) && (wb_rd_i == id_rt_i);
         assign op1 = wb_hit_rs ? wb_data_i : id_rd1_i;
         assign op2 = wb_hit_rt ? wb_data_i : id_rd2_i;
      end else begin : g_no_bypass
         assign op1 = id_rd1_i;
         assign op2 = id_rd2_i;
      end
   endgenerate

   // A flush suppresses the load-use stall: the dependent instruction is
   // being killed anyway. An external hold always propagates upstream.
   assign id_stall_o = stall_in_i || (hazard && !flush_i);

   always_comb begin
      upd_sel = UPD_LOAD;
      if (flush_i)         upd_sel = UPD_FLUSH;
      else if (stall_in_i) upd_sel = UPD_HOLD;
      else if (hazard)     upd_sel = UPD_BUBBLE;
   end

   always_comb begin
      ex_valid_d    = ex_valid_q;
      ex_pc_d       = ex_pc_q;
      ex_rd1_d      = ex_rd1_q;
      ex_rd2_d      = ex_rd2_q;
      ex_imm_d      = ex_imm_q;
      ex_rs_d       = ex_rs_q;
      ex_rt_d       = ex_rt_q;
      ex_rd_d       = ex_rd_q;
      ex_ctrl_d     = ex_ctrl_q;
      ex_mem_read_d = ex_mem_read_q;
      bubble_cnt_d  = bubble_cnt_q;

      case (upd_sel)
         UPD_FLUSH, UPD_BUBBLE: begin
            // Data and index fields hold; only the side-effect bits die.
            ex_valid_d    = 1'b0;
            ex_ctrl_d     = '0;
            ex_mem_read_d = 1'b0;
            if (upd_sel == UPD_BUBBLE && bubble_cnt_q != {BCNT_W{1'b1}})
               bubble_cnt_d = bubble_cnt_q + BCNT_W'(1);
         end
         UPD_HOLD: begin
         end
         default: begin
            ex_valid_d    = id_valid_i;
            ex_pc_d       = id_pc_i;
            ex_rd1_d      = op1;
            ex_rd2_d      = op2;
            ex_imm_d      = id_imm_i;
            ex_rs_d       = id_rs_i;
            ex_rt_d       = id_rt_i;
            ex_rd_d       = id_rd_i;
            ex_ctrl_d     = id_valid_i ? id_ctrl_i : '0;
            ex_mem_read_d = id_valid_i && id_mem_read_i;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_valid_q    <= 1'b0;
         ex_pc_q       <= '0;
         ex_rd1_q      <= '0;
         ex_rd2_q      <= '0;
         ex_imm_q      <= '0;
         ex_rs_q       <= '0;
         ex_rt_q       <= '0;
         ex_rd_q       <= '0;
         ex_ctrl_q     <= '0;
         ex_mem_read_q <= 1'b0;
         bubble_cnt_q  <= '0;
      end else begin
         ex_valid_q    <= ex_valid_d;
         ex_pc_q       <= ex_pc_d;
         ex_rd1_q      <= ex_rd1_d;
         ex_rd2_q      <= ex_rd2_d;
         ex_imm_q      <= ex_imm_d;
         ex_rs_q       <= ex_rs_d;
         ex_rt_q       <= ex_rt_d;
         ex_rd_q       <= ex_rd_d;
         ex_ctrl_q     <= ex_ctrl_d;
         ex_mem_read_q <= ex_mem_read_d;
         bubble_cnt_q  <= bubble_cnt_d;
      end
   end

   assign ex_valid_o    = ex_valid_q;
   assign ex_pc_o       = ex_pc_q;
   assign ex_rd1_o      = ex_rd1_q;
   assign ex_rd2_o      = ex_rd2_q;
   assign ex_imm_o      = ex_imm_q;
   assign ex_rs_o       = ex_rs_q;
   assign ex_rt_o       = ex_rt_q;
   assign ex_rd_o       = ex_rd_q;
   assign ex_ctrl_o     = ex_ctrl_q;
   assign ex_mem_read_o = ex_mem_read_q;
   assign bubble_cnt_o  = bubble_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_id_ex_stage_reg
//  Purpose  : Directed self-checking bench for id_ex_stage_reg. Three
//             instances share one stimulus: default build, a build without
//             WB bypass, and a build with a 2-bit bubble counter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage_reg;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid;
   logic [31:0] id_pc, id_rd1, id_rd2, id_imm;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic        id_uses_rt;
   logic [7:0]  id_ctrl;
   logic        id_mem_read;
   logic        wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        stall_in, flush;

   // Default instance outputs
   logic        ex_valid, ex_mem_read, id_stall;
   logic [31:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
   logic [4:0]  ex_rs, ex_rt, ex_rd;
   logic [7:0]  ex_ctrl;
   logic [15:0] bubble_cnt;

   // No-bypass instance outputs
   logic        nb_valid, nb_mem_read, nb_stall;
   logic [31:0] nb_pc, nb_rd1, nb_rd2, nb_imm;
   logic [4:0]  nb_rs, nb_rt, nb_rd;
   logic [7:0]  nb_ctrl;
   logic [15:0] nb_cnt;

   // 2-bit counter instance outputs
   logic        sat_valid, sat_mem_read, sat_stall;
   logic [31:0] sat_pc, sat_rd1, sat_rd2, sat_imm;
   logic [4:0]  sat_rs, sat_rt, sat_rd;
   logic [7:0]  sat_ctrl;
   logic [1:0]  sat_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   id_ex_stage_reg dut (
      .clk(clk), .rst(rst), .id_valid_i(id_valid), .id_pc_i(id_pc),
      .id_rd1_i(id_rd1), .id_rd2_i(id_rd2), .id_imm_i(id_imm),
      .id_rs_i(id_rs), .id_rt_i(id_rt), .id_rd_i(id_rd),
      .id_uses_rt_i(id_uses_rt), .id_ctrl_i(id_ctrl), .id_mem_read_i(id_mem_read),
      .wb_we_i(wb_we), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
      .stall_in_i(stall_in), .flush_i(flush),
      .ex_valid_o(ex_valid), .ex_pc_o(ex_pc), .ex_rd1_o(ex_rd1), .ex_rd2_o(ex_rd2),
      .ex_imm_o(ex_imm), .ex_rs_o(ex_rs), .ex_rt_o(ex_rt), .ex_rd_o(ex_rd),
      .ex_ctrl_o(ex_ctrl), .ex_mem_read_o(ex_mem_read), .id_stall_o(id_stall),
      .bubble_cnt_o(bubble_cnt)
   );

   id_ex_stage_reg #(.WB_BYPASS(0)) dut_nb (
      .clk(clk), .rst(rst), .id_valid_i(id_valid), .id_pc_i(id_pc),
      .id_rd1_i(id_rd1), .id_rd2_i(id_rd2), .id_imm_i(id_imm),
      .id_rs_i(id_rs), .id_rt_i(id_rt), .id_rd_i(id_rd),
      .id_uses_rt_i(id_uses_rt), .id_ctrl_i(id_ctrl), .id_mem_read_i(id_mem_read),
      .wb_we_i(wb_we), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
      .stall_in_i(stall_in), .flush_i(flush),
      .ex_valid_o(nb_valid), .ex_pc_o(nb_pc), .ex_rd1_o(nb_rd1), .ex_rd2_o(nb_rd2),
      .ex_imm_o(nb_imm), .ex_rs_o(nb_rs), .ex_rt_o(nb_rt), .ex_rd_o(nb_rd),
      .ex_ctrl_o(nb_ctrl), .ex_mem_read_o(nb_mem_read), .id_stall_o(nb_stall),
      .bubble_cnt_o(nb_cnt)
   );

   id_ex_stage_reg #(.BCNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .id_valid_i(id_valid), .id_pc_i(id_pc),
      .id_rd1_i(id_rd1), .id_rd2_i(id_rd2), .id_imm_i(id_imm),
      .id_rs_i(id_rs), .id_rt_i(id_rt), .id_rd_i(id_rd),
      .id_uses_rt_i(id_uses_rt), .id_ctrl_i(id_ctrl), .id_mem_read_i(id_mem_read),
      .wb_we_i(wb_we), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
      .stall_in_i(stall_in), .flush_i(flush),
      .ex_valid_o(sat_valid), .ex_pc_o(sat_pc), .ex_rd1_o(sat_rd1), .ex_rd2_o(sat_rd2),
      .ex_imm_o(sat_imm), .ex_rs_o(sat_rs), .ex_rt_o(sat_rt), .ex_rd_o(sat_rd),
      .ex_ctrl_o(sat_ctrl), .ex_mem_read_o(sat_mem_read), .id_stall_o(sat_stall),
      .bubble_cnt_o(sat_cnt)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one edge; sampling happens 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive a decode instruction (id_valid=1).
   task automatic drive(input logic [31:0] pc, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic uses_rt, input logic mem_rd,
                        input logic [7:0] ctrl, input logic [31:0] rd1, input logic [31:0] rd2);
      id_valid    = 1'b1;
      id_pc       = pc;
      id_rs       = rs;
      id_rt       = rt;
      id_rd       = rd;
      id_uses_rt  = uses_rt;
      id_mem_read = mem_rd;
      id_ctrl     = ctrl;
      id_rd1      = rd1;
      id_rd2      = rd2;
      id_imm      = pc ^ 32'h0000_00F0;
   endtask

   initial begin
      rst = 1'b1; id_valid = 1'b0; id_pc = '0; id_rd1 = '0; id_rd2 = '0; id_imm = '0;
      id_rs = '0; id_rt = '0; id_rd = '0; id_uses_rt = 1'b0; id_ctrl = '0;
      id_mem_read = 1'b0; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
      stall_in = 1'b0; flush = 1'b0;

      // ---- reset state ----
      tick(); tick();
      rst = 1'b0;
      tick();
      check("rst_valid", ex_valid, 0);
      check("rst_pc", ex_pc, 0);
      check("rst_ctrl", ex_ctrl, 0);
      check("rst_cnt", bubble_cnt, 0);
      check("rst_stall", id_stall, 0);

      // ---- plain load ----
      drive(32'h0040_0004, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 8'h5A, 32'h1234, 32'h5678);
      tick();
      check("ld_pc", ex_pc, 32'h0040_0004);
      check("ld_rd1", ex_rd1, 32'h1234);
      check("ld_rd2", ex_rd2, 32'h5678);
      check("ld_imm", ex_imm, 32'h0040_00F4);
      check("ld_ctrl", ex_ctrl, 8'h5A);
      check("ld_valid", ex_valid, 1);
      check("ld_idx", {ex_rs, ex_rt, ex_rd}, {5'd1, 5'd2, 5'd3});

      // ---- load-use: lw $8 then add using $8 ----
      drive(32'h0040_0008, 5'd29, 5'd8, 5'd0, 1'b0, 1'b1, 8'h93, 32'h1000, 32'h0);
      tick();
      check("lu_lw_memrd", ex_mem_read, 1);
      drive(32'h0040_000C, 5'd8, 5'd9, 5'd10, 1'b1, 1'b0, 8'h44, 32'hAAAA, 32'hBBBB);
      #1;
      check("lu_stall", id_stall, 1);
      tick();
      check("lu_bub_valid", ex_valid, 0);
      check("lu_bub_ctrl", ex_ctrl, 0);
      check("lu_bub_memrd", ex_mem_read, 0);
      check("lu_bub_pc_hold", ex_pc, 32'h0040_0008);
      check("lu_cnt", bubble_cnt, 1);
      check("lu_stall_clear", id_stall, 0);
      tick();
      check("lu_add_valid", ex_valid, 1);
      check("lu_add_pc", ex_pc, 32'h0040_000C);
      check("lu_add_rd1", ex_rd1, 32'hAAAA);
      check("lu_add_ctrl", ex_ctrl, 8'h44);
      check("lu_cnt_keep", bubble_cnt, 1);

      // ---- $0 and rt-unused never stall ----
      drive(32'h0040_0010, 5'd5, 5'd0, 5'd0, 1'b0, 1'b1, 8'h08, 32'h0, 32'h0);
      tick();
      drive(32'h0040_0014, 5'd0, 5'd4, 5'd6, 1'b1, 1'b0, 8'h20, 32'h0, 32'h0);
      #1;
      check("z0_nostall", id_stall, 0);
      tick();
      drive(32'h0040_0018, 5'd7, 5'd9, 5'd0, 1'b0, 1'b1, 8'h08, 32'h0, 32'h0);
      tick();
      check("rt9_loaded", ex_rt, 9);
      drive(32'h0040_001C, 5'd6, 5'd9, 5'd11, 1'b0, 1'b0, 8'h20, 32'h0, 32'h0);
      #1;
      check("rt_unused_nostall", id_stall, 0);
      id_uses_rt = 1'b1;
      #1;
      check("rt_used_stall", id_stall, 1);
      id_uses_rt = 1'b0;
      tick();
      check("rt_unused_cnt", bubble_cnt, 1);

      // ---- WB bypass ----
      wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEAD_BEEF;
      drive(32'h0040_0020, 5'd3, 5'd4, 5'd12, 1'b1, 1'b0, 8'h20, 32'h0, 32'h77);
      tick();
      check("byp_rd1", ex_rd1, 32'hDEAD_BEEF);
      check("byp_rd2_nohit", ex_rd2, 32'h77);
      check("nobyp_rd1", nb_rd1, 32'h0);
      wb_rd = 5'd4;
      drive(32'h0040_0024, 5'd3, 5'd4, 5'd12, 1'b1, 1'b0, 8'h20, 32'h11, 32'h22);
      tick();
      check("byp_rd2", ex_rd2, 32'hDEAD_BEEF);
      check("byp_rd1_nohit", ex_rd1, 32'h11);
      check("nobyp_rd2", nb_rd2, 32'h22);
      wb_rd = 5'd0;
      drive(32'h0040_0028, 5'd0, 5'd4, 5'd12, 1'b1, 1'b0, 8'h20, 32'h33, 32'h44);
      tick();
      check("byp_r0_rd1", ex_rd1, 32'h33);
      wb_we = 1'b0;
      drive(32'h0040_002C, 5'd3, 5'd4, 5'd12, 1'b1, 1'b0, 8'h20, 32'h55, 32'h66);
      tick();
      check("byp_we0_rd1", ex_rd1, 32'h55);

      // ---- external hold ----
      drive(32'h0040_0030, 5'd13, 5'd14, 5'd15, 1'b1, 1'b0, 8'h3C, 32'h99, 32'h0);
      stall_in = 1'b1;
      #1;
      check("hold_stall_out", id_stall, 1);
      tick();
      check("hold_pc", ex_pc, 32'h0040_002C);
      check("hold_valid", ex_valid, 1);
      stall_in = 1'b0;
      tick();
      check("hold_release_pc", ex_pc, 32'h0040_0030);

      // ---- flush + stall_in + hazard in one cycle ----
      drive(32'h0040_0034, 5'd1, 5'd8, 5'd0, 1'b0, 1'b1, 8'h10, 32'h0, 32'h0);
      tick();
      drive(32'h0040_0038, 5'd8, 5'd2, 5'd3, 1'b1, 1'b0, 8'h44, 32'h0, 32'h0);
      flush = 1'b1; stall_in = 1'b1;
      #1;
      check("prio_stall", id_stall, 1);
      tick();
      check("prio_valid", ex_valid, 0);
      check("prio_ctrl", ex_ctrl, 0);
      check("prio_cnt", bubble_cnt, 1);
      check("prio_rt_hold", ex_rt, 8);
      flush = 1'b0; stall_in = 1'b0;
      #1;
      check("prio_after_stall", id_stall, 0);
      tick();

      // ---- saturation: four more bubbles ----
      for (int k = 0; k < 4; k++) begin
         drive(32'h0040_0100 + 32'(8 * k), 5'd1, 5'd8, 5'd0, 1'b0, 1'b1, 8'h10, 32'h0, 32'h0);
         tick();
         drive(32'h0040_0104 + 32'(8 * k), 5'd8, 5'd2, 5'd3, 1'b1, 1'b0, 8'h44, 32'h0, 32'h0);
         tick();
      end
      check("sat_main_cnt", bubble_cnt, 5);
      check("sat_2bit_cnt", sat_cnt, 3);

      // ---- async reset mid-stall ----
      drive(32'h0040_0200, 5'd1, 5'd8, 5'd0, 1'b0, 1'b1, 8'h10, 32'h0, 32'h0);
      tick();
      drive(32'h0040_0204, 5'd8, 5'd2, 5'd3, 1'b1, 1'b0, 8'h44, 32'h0, 32'h0);
      #1;
      check("arst_pre_stall", id_stall, 1);
      check("arst_pre_valid", ex_valid, 1);
      rst = 1'b1;
      #1;
      check("arst_valid", ex_valid, 0);
      check("arst_cnt", bubble_cnt, 0);
      check("arst_pc", ex_pc, 0);
      check("arst_ctrl", ex_ctrl, 0);
      check("arst_memrd", ex_mem_read, 0);
      check("arst_stall", id_stall, 0);
      tick();
      rst = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- Parametrised ID/EX pipeline stage register for the pipelined MIPS core.
- Extends the fixed-width ID/EX register with:
  - a valid bit;
  - stall hold and flush;
  - load-use hazard detection with bubble insertion;
  - an optional write-back-to-decode bypass of register operands;
  - a saturating bubble counter.
- Sits between decode (register file read, immediate extension) and execute (ALU, forwarding muxes).

Parameters:
- DATA_W, 32, width of PC, operand and immediate fields
- REG_AW, 5, register-index width
- CTRL_W, 8, width of opaque control bundle (ALUop, ALUSrc, RegDst, MemRead, MemWrite, RegWrite, MemtoReg, Branch)
- WB_BYPASS, 1, 1 = substitute WB write data for same-cycle register-file reads
- BCNT_W, 16, bubble-counter width

Ports:
- clk, in, 1, clock; all flops rising-edge
- rst, in, 1, asynchronous active-high reset
- id_valid, in, 1, decode holds a real instruction
- id_pc, in, DATA_W, PC+4 of decode instruction
- id_rd1, id_rd2, in, DATA_W, register-file read data
- id_imm, in, DATA_W, sign-extended immediate
- id_rs, id_rt, id_rd, in, REG_AW, register indices
- id_uses_rt, in, 1, instruction reads rt as a source
- id_ctrl, in, CTRL_W, decoded control bundle
- id_mem_read, in, 1, decode instruction is a load
- wb_we, in, 1, write-back register write enable
- wb_rd, in, REG_AW, write-back destination
- wb_data, in, DATA_W, write-back data
- stall_in, in, 1, downstream hold request
- flush, in, 1, kill decode/EX contents (taken branch/jump)
- ex_valid, out, 1, EX stage holds a real instruction
- ex_pc, ex_rd1, ex_rd2, ex_imm, out, DATA_W, registered fields
- ex_rs, ex_rt, ex_rd, out, REG_AW, registered indices
- ex_ctrl, out, CTRL_W, registered control
- ex_mem_read, out, 1, registered load flag
- id_stall, out, 1, freeze PC and IF/ID register
- bubble_cnt, out, BCNT_W, load-use bubbles inserted

Behaviour:
- Reset (async, rst=1): all registered outputs 0, including ex_valid, ex_ctrl, ex_mem_read and bubble_cnt. Outputs are 0 on the first edge after release.
- Latency: 1 cycle from decode inputs to ex_* outputs.
- Hazard (combinational) is asserted when all of the following hold:
  - ex_valid and ex_mem_read;
  - id_valid;
  - ex_rt != 0;
  - ex_rt == id_rs, or (id_uses_rt and ex_rt == id_rt).
- id_stall = stall_in | (hazard & ~flush).
- Bypass (WB_BYPASS=1):
  - op1 = wb_data when wb_we, wb_rd != 0 and wb_rd == id_rs; otherwise id_rd1.
  - op2 is formed the same way from id_rt / id_rd2.
  - With WB_BYPASS=0, op1 = id_rd1 and op2 = id_rd2.
- Per-edge update, priority highest first:
  1. flush: ex_valid=0, ex_ctrl=0, ex_mem_read=0; data/index fields hold.
  2. stall_in: every register holds, including ex_valid; bubble_cnt holds.
  3. hazard: bubble inserted. ex_valid=0, ex_ctrl=0, ex_mem_read=0; data/index fields hold; bubble_cnt increments.
  4. else load: ex_valid=id_valid; ex_pc=id_pc; ex_rd1=op1; ex_rd2=op2; ex_imm, indices, ctrl and mem_read from id_*.
     - When id_valid=0, ex_ctrl and ex_mem_read load 0.
- Hazard evaluation uses current (pre-edge) ex_* values. After a bubble, ex_mem_read=0, so the hazard clears next cycle: exactly one bubble per load-use pair.
- Back-to-back loads with dependence: each dependent pair gets its own single bubble.
- bubble_cnt saturates at all-ones; there is no wrap.
- Reset asserted mid-stall or mid-bubble: immediate clear, no residual id_stall (hazard requires ex_valid).
- Index 0 never triggers a hazard or a bypass.

Decomposition:
- Shared package mips_pipe_pkg holds:
  - CTRL_W and the control-bundle bit positions (CTRL_ALUOP_LSB, CTRL_ALUSRC, CTRL_REGDST, CTRL_MEMREAD, CTRL_MEMWRITE, CTRL_REGWRITE, CTRL_MEMTOREG, CTRL_BRANCH);
  - REG_ZERO constant.
- One sub-module, load_use_detect: combinational hazard compare, reusable by future stages.
- Bypass muxes and the counter stay inline.

Test Plan:
- Reset: rst=1 mid-run with ex_valid=1 and bubble_cnt=5 -> all outputs 0 asynchronously, before the next clk edge.
- Plain load: id_pc=0x0040_0004, id_rd1=0x1234, id_ctrl=0x5A, id_valid=1 -> next cycle ex_pc=0x0040_0004, ex_rd1=0x1234, ex_ctrl=0x5A, ex_valid=1.
- Load-use: lw $8 in EX (ex_mem_read=1, ex_rt=8), then add with id_rs=8 -> id_stall=1 for 1 cycle; ex_valid=0 and ex_ctrl=0 for 1 cycle; bubble_cnt 0->1; add enters EX on the following edge.
- $0 and rt-unused: ex_rt=0, id_rs=0 -> no stall. ex_rt=9, id_rt=9, id_uses_rt=0 -> no stall.
- WB bypass: wb_we=1, wb_rd=3, wb_data=0xDEAD_BEEF, id_rs=3, id_rd1=0x0 -> ex_rd1=0xDEAD_BEEF. Same with WB_BYPASS=0 -> ex_rd1=0x0.
- Priority: flush=1, stall_in=1 and hazard=1 in one cycle -> ex_valid=0, id_stall=1 (from stall_in), bubble_cnt unchanged. With BCNT_W=2 and 4 bubbles -> bubble_cnt stays 3.
